// File: rtl/sram_uart_bridge.sv
// sram_uart_bridge: memory-mapped bridge from the CPU request port to the
// BaseRAM / ExtRAM asynchronous SRAMs and the direct UART transmitter/receiver.
// SRAM strobes are held for SRAM_WAIT cycles; UART exposes data and status regs.
module sram_uart_bridge #(
  parameter int unsigned SRAM_WAIT      = 2,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_addr,
  input  logic        cpu_req_we,
  input  logic [3:0]  cpu_req_be,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_resp_rdata,
  inout  wire  [31:0] base_ram_data,
  output logic [19:0] base_ram_addr,
  output logic [3:0]  base_ram_be_n,
  output logic        base_ram_ce_n,
  output logic        base_ram_oe_n,
  output logic        base_ram_we_n,
  inout  wire  [31:0] ext_ram_data,
  output logic [19:0] ext_ram_addr,
  output logic [3:0]  ext_ram_be_n,
  output logic        ext_ram_ce_n,
  output logic        ext_ram_oe_n,
  output logic        ext_ram_we_n,
  output logic        uart_tx_start,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_busy,
  input  logic        uart_rx_ready,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_clear
);

  typedef enum logic [1:0] {S_IDLE, S_SRAM, S_TXWAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_sel_ext;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_base_drv;
  logic        r_ext_drv;
  logic [7:0]  r_rx_buf;
  logic        r_rx_valid;
  logic        r_overrun;

  logic        w_accept;
  logic        w_is_base;
  logic        w_is_ext;
  logic        w_is_udata;
  logic        w_is_ustat;
  logic        w_rd_clr;
  logic        w_ov_clr;
  logic [31:0] w_stat;

  assign cpu_req_ready = (r_state == S_IDLE);
  assign w_accept      = cpu_req_valid && cpu_req_ready;
  assign w_is_base     = (cpu_req_addr[31:22] == 10'h200);
  assign w_is_ext      = (cpu_req_addr[31:22] == 10'h201);
  assign w_is_udata    = (cpu_req_addr == UART_DATA_ADDR);
  assign w_is_ustat    = (cpu_req_addr == UART_STAT_ADDR);
  assign w_rd_clr      = w_accept && w_is_udata && !cpu_req_we;
  assign w_ov_clr      = w_accept && w_is_ustat && !cpu_req_we;
  assign w_stat        = {29'b0, r_overrun, r_rx_valid, ~uart_tx_busy};
  assign uart_rx_clear = uart_rx_ready;

  // Write data stays on the selected bus from SRAM entry through RESP.
  assign base_ram_data = r_base_drv ? r_wdata : 32'hzzzz_zzzz;
  assign ext_ram_data  = r_ext_drv  ? r_wdata : 32'hzzzz_zzzz;

  // Receive capture runs every cycle; a new byte arriving with a read clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_buf   <= 8'h00;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (uart_rx_ready) begin
      r_rx_buf   <= uart_rx_data;
      r_rx_valid <= 1'b1;
      r_overrun  <= (r_overrun && !w_ov_clr) || (r_rx_valid && !w_rd_clr);
    end else begin
      if (w_rd_clr) r_rx_valid <= 1'b0;
      if (w_ov_clr) r_overrun  <= 1'b0;
    end
  end

  // Request FSM: decode, SRAM strobe sequencing, UART transmit handshake, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_sel_ext      <= 1'b0;
      r_we           <= 1'b0;
      r_wdata        <= 32'h0;
      r_base_drv     <= 1'b0;
      r_ext_drv      <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= 32'h0;
      base_ram_addr  <= 20'h0;
      base_ram_be_n  <= 4'hF;
      base_ram_ce_n  <= 1'b1;
      base_ram_oe_n  <= 1'b1;
      base_ram_we_n  <= 1'b1;
      ext_ram_addr   <= 20'h0;
      ext_ram_be_n   <= 4'hF;
      ext_ram_ce_n   <= 1'b1;
      ext_ram_oe_n   <= 1'b1;
      ext_ram_we_n   <= 1'b1;
      uart_tx_start  <= 1'b0;
      uart_tx_data   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= cpu_req_we;
            r_wdata <= cpu_req_wdata;
            if (w_is_base || w_is_ext) begin
              r_state   <= S_SRAM;
              r_cnt     <= 4'(SRAM_WAIT - 1);
              r_sel_ext <= w_is_ext;
              if (w_is_ext) begin
                ext_ram_ce_n <= 1'b0;
                ext_ram_oe_n <= cpu_req_we;
                ext_ram_we_n <= !cpu_req_we;
                ext_ram_be_n <= cpu_req_we ? ~cpu_req_be : 4'h0;
                ext_ram_addr <= cpu_req_addr[21:2];
                r_ext_drv    <= cpu_req_we;
              end else begin
                base_ram_ce_n <= 1'b0;
                base_ram_oe_n <= cpu_req_we;
                base_ram_we_n <= !cpu_req_we;
                base_ram_be_n <= cpu_req_we ? ~cpu_req_be : 4'h0;
                base_ram_addr <= cpu_req_addr[21:2];
                r_base_drv    <= cpu_req_we;
              end
            end else if (w_is_udata && cpu_req_we) begin
              r_state <= S_TXWAIT;
            end else begin
              r_state        <= S_RESP;
              cpu_resp_valid <= 1'b1;
              if (cpu_req_we)      cpu_resp_rdata <= 32'h0;
              else if (w_is_udata) cpu_resp_rdata <= {24'b0, r_rx_buf};
              else if (w_is_ustat) cpu_resp_rdata <= w_stat;
              else                 cpu_resp_rdata <= 32'h0;
            end
          end
        end
        S_SRAM: begin
          if (r_cnt == 4'd0) begin
            base_ram_ce_n  <= 1'b1;
            base_ram_oe_n  <= 1'b1;
            base_ram_we_n  <= 1'b1;
            ext_ram_ce_n   <= 1'b1;
            ext_ram_oe_n   <= 1'b1;
            ext_ram_we_n   <= 1'b1;
            cpu_resp_valid <= 1'b1;
            cpu_resp_rdata <= r_we ? 32'h0 : (r_sel_ext ? ext_ram_data : base_ram_data);
            r_state        <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_TXWAIT: begin
          if (uart_tx_start) begin
            uart_tx_start  <= 1'b0;
            cpu_resp_valid <= 1'b1;
            cpu_resp_rdata <= 32'h0;
            r_state        <= S_RESP;
          end else if (!uart_tx_busy) begin
            uart_tx_start <= 1'b1;
            uart_tx_data  <= r_wdata[7:0];
          end
        end
        S_RESP: begin
          cpu_resp_valid <= 1'b0;
          r_base_drv     <= 1'b0;
          r_ext_drv      <= 1'b0;
          base_ram_be_n  <= 4'hF;
          ext_ram_be_n   <= 4'hF;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_bridge.sv
// Self-checking bench for sram_uart_bridge: directed scenarios plus randomized
// traffic against a behavioural model of both SRAMs and the UART registers.
module tb_sram_uart_bridge;

  localparam int          SRAM_WAIT = 2;
  localparam logic [31:0] UDATA     = 32'hBFD0_03F8;
  localparam logic [31:0] USTAT     = 32'hBFD0_03FC;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr;
  logic        cpu_req_we;
  logic [3:0]  cpu_req_be;
  logic [31:0] cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  wire  [31:0] ext_ram_data;
  logic [19:0] ext_ram_addr;
  logic [3:0]  ext_ram_be_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic        uart_rx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_clear;

  always #5 clk = ~clk;

  sram_uart_bridge #(
    .SRAM_WAIT(SRAM_WAIT), .UART_DATA_ADDR(UDATA), .UART_STAT_ADDR(USTAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
    .cpu_req_be(cpu_req_be), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy), .uart_rx_ready(uart_rx_ready),
    .uart_rx_data(uart_rx_data), .uart_rx_clear(uart_rx_clear)
  );

  // Board SRAM devices (256 words each) and reference copies
  logic [31:0] base_dev [0:255];
  logic [31:0] ext_dev  [0:255];
  logic [31:0] base_ref [0:255];
  logic [31:0] ext_ref  [0:255];
  logic        mem_init;

  function automatic logic [31:0] init_word(input bit is_ext, input int i);
    if (!is_ext && i == 4) return 32'h1234_5678;
    if (is_ext && i == 1)  return 32'h0;
    return {is_ext ? 8'hE0 : 8'hB0, 8'(i), 8'(i * 7), 8'(255 - i)};
  endfunction

  assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? base_dev[base_ram_addr[7:0]] : 32'hzzzz_zzzz;
  assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? ext_dev[ext_ram_addr[7:0]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        base_dev[i] <= init_word(1'b0, i);
        ext_dev[i]  <= init_word(1'b1, i);
      end
    end else begin
      if (!base_ram_ce_n && !base_ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!base_ram_be_n[b]) base_dev[base_ram_addr[7:0]][8*b +: 8] <= base_ram_data[8*b +: 8];
      if (!ext_ram_ce_n && !ext_ram_we_n)
        for (int b = 0; b < 4; b++)
          if (!ext_ram_be_n[b]) ext_dev[ext_ram_addr[7:0]][8*b +: 8] <= ext_ram_data[8*b +: 8];
    end
  end

  // UART register model
  logic [7:0] m_buf;
  logic       m_vld;
  logic       m_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Per-transaction observations
  int          mon_base_ce, mon_base_oe, mon_base_we;
  int          mon_ext_ce, mon_ext_oe, mon_ext_we;
  int          mon_tx;
  logic [7:0]  mon_tx_data;
  logic [19:0] mon_addr;
  logic [3:0]  mon_be_n;
  logic [31:0] mon_base_bus, mon_ext_bus;
  logic        mon_we_n_resp;

  task automatic xact(input logic [31:0] a, input logic w, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output int lat);
    int  n;
    bit  first;
    mon_base_ce = 0; mon_base_oe = 0; mon_base_we = 0;
    mon_ext_ce = 0;  mon_ext_oe = 0;  mon_ext_we = 0;
    mon_tx = 0; mon_tx_data = 8'h00; mon_addr = 20'h0; mon_be_n = 4'hF;
    mon_base_bus = 32'h0; mon_ext_bus = 32'h0; mon_we_n_resp = 1'b0;
    first = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_addr = a; cpu_req_we = w; cpu_req_be = b; cpu_req_wdata = d;
    n = 0;
    while (!cpu_req_ready && n < 50) begin @(negedge clk); n++; end
    if (!cpu_req_ready) check_val("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    lat = 0; rd = 32'h0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (!base_ram_ce_n) mon_base_ce++;
      if (!base_ram_oe_n) mon_base_oe++;
      if (!base_ram_we_n) mon_base_we++;
      if (!ext_ram_ce_n)  mon_ext_ce++;
      if (!ext_ram_oe_n)  mon_ext_oe++;
      if (!ext_ram_we_n)  mon_ext_we++;
      if (first && (!base_ram_ce_n || !ext_ram_ce_n)) begin
        mon_addr = !base_ram_ce_n ? base_ram_addr : ext_ram_addr;
        mon_be_n = !base_ram_ce_n ? base_ram_be_n : ext_ram_be_n;
        first = 1'b0;
      end
      if (uart_tx_start) begin mon_tx++; mon_tx_data = uart_tx_data; end
      if (cpu_resp_valid) begin
        rd = cpu_resp_rdata;
        mon_base_bus = base_ram_data;
        mon_ext_bus  = ext_ram_data;
        mon_we_n_resp = base_ram_we_n & ext_ram_we_n & base_ram_ce_n & ext_ram_ce_n;
        break;
      end
    end
    if (!cpu_resp_valid) check_val("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_val("resp_pulse", {30'b0, cpu_resp_valid, cpu_req_ready}, 32'h1);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(negedge clk);
    uart_rx_ready = 1'b1; uart_rx_data = d;
    #1 check_val("rx_clear", {31'b0, uart_rx_clear}, 32'h1);
    m_ovr = m_ovr | m_vld; m_vld = 1'b1; m_buf = d;
    @(negedge clk);
    uart_rx_ready = 1'b0;
  endtask

  task automatic sram_op(input bit is_ext, input bit w, input int idx,
                         input logic [3:0] b, input logic [31:0] d);
    logic [31:0] rd, exp;
    int          lat;
    logic [31:0] a;
    a = (is_ext ? 32'h8040_0000 : 32'h8000_0000) | (32'(idx) << 2);
    exp = is_ext ? ext_ref[idx] : base_ref[idx];
    xact(a, w, b, d, rd, lat);
    check_val("sram_lat", lat, SRAM_WAIT + 1);
    check_val("sram_addr", {12'b0, mon_addr}, 32'(idx));
    check_val("sram_ce_sel", is_ext ? mon_ext_ce : mon_base_ce, SRAM_WAIT);
    check_val("sram_ce_other", is_ext ? mon_base_ce : mon_ext_ce, 0);
    check_val("sram_strobes_resp", {31'b0, mon_we_n_resp}, 32'h1);
    if (w) begin
      check_val("sram_we_cnt", is_ext ? mon_ext_we : mon_base_we, SRAM_WAIT);
      check_val("sram_oe_wr", mon_base_oe + mon_ext_oe, 0);
      check_val("sram_be_n_wr", {28'b0, mon_be_n}, {28'b0, ~b});
      check_val("sram_bus_hold", is_ext ? mon_ext_bus : mon_base_bus, d);
      check_val("sram_wr_rdata", rd, 32'h0);
      for (int k = 0; k < 4; k++)
        if (b[k]) begin
          if (is_ext) ext_ref[idx][8*k +: 8] = d[8*k +: 8];
          else        base_ref[idx][8*k +: 8] = d[8*k +: 8];
        end
    end else begin
      check_val("sram_oe_cnt", is_ext ? mon_ext_oe : mon_base_oe, SRAM_WAIT);
      check_val("sram_we_rd", mon_base_we + mon_ext_we, 0);
      check_val("sram_be_n_rd", {28'b0, mon_be_n}, 32'h0);
      check_val("sram_rdata", rd, exp);
    end
  endtask

  task automatic uart_read(input bit stat);
    logic [31:0] rd, exp;
    int          lat;
    if (stat) begin
      exp = {29'b0, m_ovr, m_vld, ~uart_tx_busy};
      m_ovr = 1'b0;
    end else begin
      exp = {24'b0, m_buf};
      m_vld = 1'b0;
    end
    xact(stat ? USTAT : UDATA, 1'b0, 4'hF, 32'h0, rd, lat);
    check_val(stat ? "stat_rdata" : "udata_rdata", rd, exp);
    check_val("uart_rd_lat", lat, 1);
  endtask

  task automatic unmapped(input logic [31:0] a, input bit w);
    logic [31:0] rd;
    int          lat;
    xact(a, w, 4'hF, $urandom, rd, lat);
    check_val("unmap_rdata", rd, 32'h0);
    check_val("unmap_lat", lat, 1);
    check_val("unmap_strobes", mon_base_ce + mon_ext_ce + mon_tx, 0);
  endtask

  task automatic tx_write(input logic [7:0] d);
    logic [31:0] rd;
    int          lat;
    xact(UDATA, 1'b1, 4'h1, {24'hABCDEF, d}, rd, lat);
    check_val("tx_count", mon_tx, 1);
    check_val("tx_data", {24'b0, mon_tx_data}, {24'b0, d});
    check_val("tx_lat", lat, 3);
    check_val("tx_rdata", rd, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat, n, seen;
    rst = 1'b1; mem_init = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_addr = 32'h0; cpu_req_we = 1'b0;
    cpu_req_be = 4'h0; cpu_req_wdata = 32'h0;
    uart_tx_busy = 1'b0; uart_rx_ready = 1'b0; uart_rx_data = 8'h00;
    m_buf = 8'h00; m_vld = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      base_ref[i] = init_word(1'b0, i);
      ext_ref[i]  = init_word(1'b1, i);
    end
    repeat (3) @(negedge clk);
    check_val("rst_ready_resp", {30'b0, cpu_req_ready, cpu_resp_valid}, 32'h2);
    check_val("rst_rdata", cpu_resp_rdata, 32'h0);
    check_val("rst_strobes", {26'b0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                              ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 32'h3F);
    check_val("rst_be_n", {24'b0, base_ram_be_n, ext_ram_be_n}, 32'hFF);
    check_val("rst_addr", {12'b0, base_ram_addr | ext_ram_addr}, 32'h0);
    check_val("rst_tx", {23'b0, uart_tx_start, uart_tx_data}, 32'h0);
    rst = 1'b0; mem_init = 1'b0;

    // Directed SRAM read and write/readback
    sram_op(1'b0, 1'b0, 4, 4'hF, 32'h0);
    sram_op(1'b1, 1'b1, 1, 4'b0011, 32'hAABB_CCDD);
    sram_op(1'b1, 1'b0, 1, 4'hF, 32'h0);
    check_val("ext_readback_model", ext_ref[1], 32'h0000_CCDD);

    // Transmit stalled by a busy transmitter
    uart_tx_busy = 1'b1;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_addr = UDATA; cpu_req_we = 1'b1;
    cpu_req_be = 4'h1; cpu_req_wdata = 32'h0000_0041;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (uart_tx_start || cpu_resp_valid || cpu_req_ready) seen++;
    end
    check_val("tx_stall", seen, 0);
    uart_tx_busy = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!uart_tx_start && n < 20);
    check_val("tx_start_lat", n, 1);
    check_val("tx_start_data", {23'b0, cpu_resp_valid, uart_tx_data}, 32'h41);
    @(negedge clk);
    check_val("tx_then_resp", {30'b0, uart_tx_start, cpu_resp_valid}, 32'h1);
    @(negedge clk);
    check_val("tx_done_idle", {30'b0, cpu_resp_valid, cpu_req_ready}, 32'h1);

    // Receive path, status and overrun
    uart_read(1'b1);
    rx_pulse(8'h5A);
    uart_read(1'b1);
    uart_read(1'b0);
    check_val("udata_5a", {24'b0, m_buf}, 32'h5A);
    uart_read(1'b1);
    rx_pulse(8'h01);
    rx_pulse(8'h02);
    uart_read(1'b1);
    uart_read(1'b0);
    uart_read(1'b1);

    // Unmapped accesses and status write
    unmapped(32'h9000_0000, 1'b0);
    unmapped(32'h8080_0000, 1'b1);
    unmapped(USTAT, 1'b1);
    uart_read(1'b1);

    // Reset in the middle of an SRAM read aborts it silently
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h8000_0020; cpu_req_we = 1'b0; cpu_req_be = 4'hF;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    @(negedge clk);
    check_val("mid_access_ce", {31'b0, base_ram_ce_n}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_strobes", {29'b0, base_ram_ce_n, base_ram_oe_n, cpu_resp_valid}, 32'h6);
    rst = 1'b0;
    m_buf = 8'h00; m_vld = 1'b0; m_ovr = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) seen++;
    end
    check_val("abort_no_resp", seen, 0);
    check_val("abort_ready", {31'b0, cpu_req_ready}, 32'h1);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 8))
        0, 1: sram_op(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 4'($urandom), $urandom);
        2, 3: sram_op(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 4'($urandom), $urandom);
        4: rx_pulse(8'($urandom));
        5: uart_read(1'b1);
        6: uart_read(1'b0);
        7: unmapped(32'h0000_1000 + 32'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        default: tx_write(8'($urandom));
      endcase
    end

    // Final sweep of a few words against the reference
    for (int i = 0; i < 8; i++) begin
      sram_op(1'b0, 1'b0, i * 31, 4'hF, 32'h0);
      sram_op(1'b1, 1'b0, i * 29, 4'hF, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_uart_bridge.md
Name: sram_uart_bridge

Overview:
Memory-mapped bus bridge between the CPU core's single data/instruction request port and the board's BaseRAM, ExtRAM and direct-UART modules (async_transmitter/async_receiver). Decodes each CPU request, sequences the asynchronous SRAM control strobes with a fixed wait count, and exposes UART data/status registers. It sits directly below CPU_top and drives the thinpad top-level SRAM pins.

Parameters:
SRAM_WAIT, 2, cycles strobes are held per SRAM access (1..15)
UART_DATA_ADDR, 32'hBFD0_03F8, UART data register address
UART_STAT_ADDR, 32'hBFD0_03FC, UART status register address

Ports:
clk  in  1  system clock (clk_50M domain)
rst  in  1  synchronous active-high reset
cpu_req_valid  in  1  request present
cpu_req_ready  out  1  bridge accepts request this cycle
cpu_req_addr  in  32  byte address
cpu_req_we  in  1  1=write
cpu_req_be  in  4  byte enables, active high
cpu_req_wdata  in  32  write data
cpu_resp_valid  out  1  one-cycle completion pulse (reads and writes)
cpu_resp_rdata  out  32  read data, valid with cpu_resp_valid
base_ram_data  inout  32  BaseRAM data
base_ram_addr  out  20  BaseRAM word address
base_ram_be_n  out  4  byte enables, active low
base_ram_ce_n / base_ram_oe_n / base_ram_we_n  out  1 each  active-low strobes
ext_ram_data, ext_ram_addr, ext_ram_be_n, ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n  same as BaseRAM set
uart_tx_start  out  1  one-cycle transmit pulse
uart_tx_data  out  8  byte to transmit
uart_tx_busy  in  1  transmitter busy
uart_rx_ready  in  1  receiver has byte
uart_rx_data  in  8  received byte
uart_rx_clear  out  1  receiver flag clear

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_rdata=0; all ce_n/oe_n/we_n=1, be_n=4'hF, addr=0, both data buses hi-Z; uart_tx_start=0, uart_tx_data=0; rx_buf=0, rx_valid=0, overrun=0. Reset mid-access aborts it with no response.
- Decode: 0x8000_0000–0x803F_FFFF → BaseRAM; 0x8040_0000–0x807F_FFFF → ExtRAM; addr[21:2] → *_ram_addr. UART_DATA_ADDR/UART_STAT_ADDR → UART. Anything else: read returns 0, write dropped, response in 1 cycle.
- States: IDLE, SRAM, TXWAIT, RESP. cpu_req_ready=1 only in IDLE; accept = valid&&ready at edge, request latched.
- SRAM: selected ce_n=0 for SRAM_WAIT cycles; read: oe_n=0, be_n=0000, data hi-Z, bus sampled into cpu_resp_rdata on last cycle's edge; write: we_n=0, be_n=~be, data driven from SRAM entry through the RESP cycle (hold), we_n/ce_n=1 in RESP. Unselected chip stays inactive. Latency: accept edge → cpu_resp_valid high SRAM_WAIT+1 cycles later, for exactly 1 cycle; next accept possible the cycle after.
- UART data write: TXWAIT until uart_tx_busy=0, then uart_tx_start=1 for one cycle with uart_tx_data=wdata[7:0], then RESP. Busy at accept → stall indefinitely.
- UART data read: returns {24'b0,rx_buf}, clears rx_valid at RESP. Status read: {29'b0, overrun, rx_valid, ~uart_tx_busy}; clears overrun. UART reads/status: resp 1 cycle after accept. Writes to status ignored.
- RX capture (every cycle, independent of state): uart_rx_clear=uart_rx_ready (combinational); on uart_rx_ready: rx_buf<=uart_rx_data, rx_valid<=1, overrun<=overrun|rx_valid. Capture coinciding with data-read clear: read returns old byte, rx_valid stays 1 with new byte, overrun not set.
- cpu_resp_rdata holds last value outside RESP; writes return 0.

Test Plan:
- Reset then read 0x8000_0010, SRAM_WAIT=2, bench SRAM returns 0x1234_5678 → base_ram_addr=0x00004, oe_n/ce_n low 2 cycles, resp_valid 3 cycles after accept, rdata=0x1234_5678; ext strobes stay 1.
- Write 0x8040_0004 data 0xAABB_CCDD be=4'b0011 → ext ce_n/we_n low 2 cycles, ext_ram_be_n=4'b1100, data driven until resp; then read back 0x0000_CCDD from model.
- uart_tx_busy=1, write 0x41 to 0xBFD0_03F8 → no uart_tx_start, ready=0; drop busy → one-cycle start with tx_data=0x41, resp next cycle.
- Pulse uart_rx_ready with 0x5A → status read=0x2 (tx idle=1 → 0x3); data read=0x5A; status then 0x1.
- Two rx bytes 0x01,0x02 without read → status bit2=1, data read=0x02; second status read bit2=0.
- Read 0x9000_0000 → rdata=0, 1-cycle resp, no strobes; assert rst during SRAM read → strobes 1 next cycle, no resp_valid.
